// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and its matching detector.
package pattern_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_GAP   = 3'd2,
      ST_DONE  = 3'd3
   } tx_state_t;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
   localparam int         DEFAULT_GAP     = 2;

endpackage

// File: rtl/serial_pattern_tx.sv
// Repeats a 4-bit pattern MSB first, reps times, with GAP idle cycles between
// repetitions; Moore FSM, outputs decoded from registered state only.
module serial_pattern_tx
   import pattern_tx_pkg::*;
#(
   parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
   parameter int         GAP     = DEFAULT_GAP
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] reps,
   input  logic       abort,
   output logic       x,
   output logic       bit_valid,
   output logic       busy,
   output logic       done
);

   // Gap counter counts down to 0, so it is loaded with GAP-1 to give exactly GAP cycles.
   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   tx_state_t  state, state_n;
   logic [3:0] shreg, shreg_n;
   logic [3:0] repcnt, repcnt_n;
   logic [3:0] gapcnt, gapcnt_n;
   logic [1:0] bitcnt, bitcnt_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         shreg  <= 4'd0;
         repcnt <= 4'd0;
         gapcnt <= 4'd0;
         bitcnt <= 2'd0;
      end else begin
         state  <= state_n;
         shreg  <= shreg_n;
         repcnt <= repcnt_n;
         gapcnt <= gapcnt_n;
         bitcnt <= bitcnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      repcnt_n = repcnt;
      gapcnt_n = gapcnt;
      bitcnt_n = bitcnt;
      case (state)
         ST_IDLE: begin
            if (start && reps != 4'd0) begin
               repcnt_n = reps;
               shreg_n  = PATTERN;
               bitcnt_n = 2'd0;
               state_n  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_n = ST_IDLE;
            end else begin
               shreg_n  = {shreg[2:0], 1'b0};
               bitcnt_n = bitcnt + 2'd1;
               if (bitcnt == 2'd3) begin
                  repcnt_n = repcnt - 4'd1;
                  if (repcnt == 4'd1) begin
                     state_n = ST_DONE;
                  end else if (GAP > 0) begin
                     gapcnt_n = GAP_LOAD;
                     state_n  = ST_GAP;
                  end else begin
                     // back-to-back repetition, no bubble
                     shreg_n  = PATTERN;
                     bitcnt_n = 2'd0;
                  end
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_n = ST_IDLE;
            end else if (gapcnt == 4'd0) begin
               shreg_n  = PATTERN;
               bitcnt_n = 2'd0;
               state_n  = ST_SHIFT;
            end else begin
               gapcnt_n = gapcnt - 4'd1;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      x         = (state == ST_SHIFT) & shreg[3];
      bit_valid = (state == ST_SHIFT);
      busy      = (state == ST_SHIFT) || (state == ST_GAP);
      done      = (state == ST_DONE);
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Vector table plus scoreboard for serial_pattern_tx, with hand sequences for
// GAP=0 back-to-back output and asynchronous reset mid-gap.
module tb_serial_pattern_tx;
   import pattern_tx_pkg::*;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic [3:0] reps;
   logic       x, bit_valid, busy, done;
   logic       start0, abort0;
   logic [3:0] reps0;
   logic       x0, bv0, busy0, done0;

   always #5 clk = ~clk;

   serial_pattern_tx #(.PATTERN(4'b1101), .GAP(2)) dut (
      .clk(clk), .reset(reset), .start(start), .reps(reps), .abort(abort),
      .x(x), .bit_valid(bit_valid), .busy(busy), .done(done));

   serial_pattern_tx #(.PATTERN(4'b1101), .GAP(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .reps(reps0), .abort(abort0),
      .x(x0), .bit_valid(bv0), .busy(busy0), .done(done0));

   // exp = {x, bit_valid, busy, done} after the edge that samples the inputs
   typedef struct packed {
      logic       start;
      logic [3:0] reps;
      logic       abort;
      logic [3:0] exp;
   } vec_t;

   localparam logic [3:0] O_I  = 4'b0000;
   localparam logic [3:0] O_B1 = 4'b1110;
   localparam logic [3:0] O_B0 = 4'b0110;
   localparam logic [3:0] O_G  = 4'b0010;
   localparam logic [3:0] O_D  = 4'b0001;

   vec_t       vecs[$];
   logic [3:0] sb[$];
   int         n_chk  = 0;
   int         n_fail = 0;
   int         n_pop  = 0;

   function automatic void add(logic s, logic [3:0] r, logic a, logic [3:0] e);
      vec_t v;
      v.start = s; v.reps = r; v.abort = a; v.exp = e;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, logic [3:0] act, logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {x,bv,busy,done}=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         automatic logic [3:0] e = sb.pop_front();
         check($sformatf("vector_%0d", n_pop), {x, bit_valid, busy, done}, e);
         n_pop++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] exp_bits;
      reset = 1'b1; start = 1'b0; reps = 4'd0; abort = 1'b0;
      start0 = 1'b0; reps0 = 4'd0; abort0 = 1'b0;
      #2;
      check("reset_outputs", {x, bit_valid, busy, done}, O_I);
      check("reset_outputs_gap0", {x0, bv0, busy0, done0}, O_I);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      // single rep, also the first start after reset release
      add(1,1,0,O_B1); add(0,0,0,O_B1); add(0,0,0,O_B0); add(0,0,0,O_B1);
      add(0,0,0,O_D);  add(0,0,0,O_I);
      // reps==0 is ignored
      add(1,0,0,O_I);  add(0,0,0,O_I);
      // two reps with a 2-cycle gap: 10 busy cycles
      add(1,2,0,O_B1); add(0,0,0,O_B1); add(0,0,0,O_B0); add(0,0,0,O_B1);
      add(0,0,0,O_G);  add(0,0,0,O_G);
      add(0,0,0,O_B1); add(0,0,0,O_B1); add(0,0,0,O_B0); add(0,0,0,O_B1);
      add(0,0,0,O_D);  add(0,0,0,O_I);
      // start during SHIFT and DONE does not change the burst
      add(1,1,0,O_B1); add(1,5,0,O_B1); add(1,5,0,O_B0); add(0,0,0,O_B1);
      add(0,0,0,O_D);  add(1,3,0,O_I);  add(0,0,0,O_I);
      // abort together with start in IDLE: start wins
      add(1,1,1,O_B1); add(0,0,0,O_B1); add(0,0,0,O_B0); add(0,0,0,O_B1);
      add(0,0,0,O_D);  add(0,0,0,O_I);
      // abort on bit 2 of rep 1, no done, then a normal burst
      add(1,2,0,O_B1); add(0,0,0,O_B1); add(0,0,0,O_B0); add(0,0,1,O_I);
      add(0,0,0,O_I);
      add(1,1,0,O_B1); add(0,0,0,O_B1); add(0,0,0,O_B0); add(0,0,0,O_B1);
      add(0,0,0,O_D);  add(0,0,0,O_I);
      // abort during GAP, and abort in IDLE is harmless
      add(1,2,0,O_B1); add(0,0,0,O_B1); add(0,0,0,O_B0); add(0,0,0,O_B1);
      add(0,0,0,O_G);  add(0,0,1,O_I);  add(0,0,0,O_I);  add(0,0,1,O_I);

      foreach (vecs[i]) begin
         start = vecs[i].start; reps = vecs[i].reps; abort = vecs[i].abort;
         @(posedge clk); #1;
         sb.push_back(vecs[i].exp);
      end
      start = 1'b0; reps = 4'd0; abort = 1'b0;
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      // GAP=0: three reps back to back
      @(negedge clk);
      exp_bits = 12'b110111011101;
      start0 = 1'b1; reps0 = 4'd3;
      @(posedge clk); #1;
      start0 = 1'b0; reps0 = 4'd0;
      for (int i = 0; i < 12; i++) begin
         check($sformatf("gap0_bit_%0d", i), {x0, bv0, busy0, done0}, {exp_bits[11-i], 3'b110});
         @(posedge clk); #1;
      end
      check("gap0_done", {x0, bv0, busy0, done0}, O_D);
      @(posedge clk); #1;
      check("gap0_idle", {x0, bv0, busy0, done0}, O_I);

      // asynchronous reset in the middle of a gap
      @(negedge clk);
      start = 1'b1; reps = 4'd2;
      @(posedge clk); #1;
      start = 1'b0; reps = 4'd0;
      repeat (4) @(posedge clk);
      #1;
      check("pre_reset_gap", {x, bit_valid, busy, done}, O_G);
      #2 reset = 1'b1;
      #1;
      check("async_reset_mid_gap", {x, bit_valid, busy, done}, O_I);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b1; reps = 4'd1;
      @(posedge clk); #1;
      start = 1'b0; reps = 4'd0;
      check("post_reset_b0", {x, bit_valid, busy, done}, O_B1);
      @(posedge clk); #1;
      check("post_reset_b1", {x, bit_valid, busy, done}, O_B1);
      @(posedge clk); #1;
      check("post_reset_b2", {x, bit_valid, busy, done}, O_B0);
      @(posedge clk); #1;
      check("post_reset_b3", {x, bit_valid, busy, done}, O_B1);
      @(posedge clk); #1;
      check("post_reset_done", {x, bit_valid, busy, done}, O_D);
      @(posedge clk); #1;
      check("post_reset_idle", {x, bit_valid, busy, done}, O_I);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
